// File: rtl/control_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the pipelined control path.
package control_pkg;

   localparam int OPCODE_W    = 7;
   localparam int ALU_OP_BITS = 2;

   localparam logic [OPCODE_W-1:0] ALU_R     = 7'b0110011;
   localparam logic [OPCODE_W-1:0] ALU_I     = 7'b0010011;
   localparam logic [OPCODE_W-1:0] LOAD      = 7'b0000011;
   localparam logic [OPCODE_W-1:0] STORE     = 7'b0100011;
   localparam logic [OPCODE_W-1:0] BRANCH_EQ = 7'b1100011;
   localparam logic [OPCODE_W-1:0] JAL       = 7'b1101111;
   localparam logic [OPCODE_W-1:0] JALR      = 7'b1100111;
   localparam logic [OPCODE_W-1:0] LUI       = 7'b0110111;
   localparam logic [OPCODE_W-1:0] AUIPC     = 7'b0010111;

   localparam logic [ALU_OP_BITS-1:0] ADD    = 2'b00;
   localparam logic [ALU_OP_BITS-1:0] SUB    = 2'b01;
   localparam logic [ALU_OP_BITS-1:0] R_TYPE = 2'b10;
   localparam logic [ALU_OP_BITS-1:0] PASS_B = 2'b11;

   typedef struct packed {
      logic [ALU_OP_BITS-1:0] alu_op;
      logic                   alu_src;
      logic                   alu_src_a_pc;
      logic                   branch;
      logic                   jump;
      logic                   jalr;
      logic                   mem_read;
      logic                   mem_write;
      logic                   reg_write;
      logic                   mem_2_reg;
      logic                   link;
   } ctrl_t;

   // Subset still needed once the instruction has left EX.
   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jump;
      logic reg_write;
      logic mem_2_reg;
      logic link;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_2_reg;
      logic link;
   } wb_ctrl_t;

   localparam ctrl_t     CTRL_NONE     = '0;
   localparam mem_ctrl_t MEM_CTRL_NONE = '0;
   localparam wb_ctrl_t  WB_CTRL_NONE  = '0;

   function automatic mem_ctrl_t to_mem_ctrl(input ctrl_t c);
      mem_ctrl_t m;
      m.mem_read  = c.mem_read;
      m.mem_write = c.mem_write;
      m.branch    = c.branch;
      m.jump      = c.jump;
      m.reg_write = c.reg_write;
      m.mem_2_reg = c.mem_2_reg;
      m.link      = c.link;
      return m;
   endfunction

   function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t m);
      wb_ctrl_t w;
      w.reg_write = m.reg_write;
      w.mem_2_reg = m.mem_2_reg;
      w.link      = m.link;
      return w;
   endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational RISC-V opcode decode into the control bundle; unknown opcodes give an empty bundle.
module opcode_decoder
   import control_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output ctrl_t               ctrl,
   output logic                illegal
);

   always_comb begin
      ctrl    = CTRL_NONE;
      illegal = 1'b0;
      case (opcode)
         ALU_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = R_TYPE;
         end
         ALU_I: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ADD;
         end
         LOAD: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.mem_2_reg = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ADD;
         end
         STORE: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ADD;
         end
         BRANCH_EQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = SUB;
         end
         JAL: begin
            ctrl.branch    = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.link      = 1'b1;
            ctrl.alu_op    = ADD;
         end
         JALR: begin
            ctrl.jump      = 1'b1;
            ctrl.jalr      = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.link      = 1'b1;
            ctrl.alu_op    = ADD;
         end
         LUI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = PASS_B;
         end
         AUIPC: begin
            ctrl.alu_src      = 1'b1;
            ctrl.alu_src_a_pc = 1'b1;
            ctrl.reg_write    = 1'b1;
            ctrl.alu_op       = ADD;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control path: decode in ID, bundle carried through ID/EX, EX/MEM and MEM/WB
// with load-use detection, external stall and branch flush.
module pipelined_control_unit
   import control_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int HAZARD_EN  = 1,
   parameter int ALU_OP_W   = 2
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [OPCODE_W-1:0]   id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  stall_ext,
   input  logic                  flush,
   output logic                  load_use_stall,
   output logic                  illegal_op,
   output logic                  ex_valid,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic                  ex_alu_src,
   output logic                  ex_alu_src_a_pc,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic                  ex_jalr,
   output logic                  mem_valid,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic                  mem_branch,
   output logic                  mem_jump,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic                  wb_mem_2_reg,
   output logic                  wb_link,
   output logic [REG_ADDR_W-1:0] wb_rd
);

   ctrl_t                 id_ctrl;
   logic                  id_illegal;
   logic                  id_take;

   ctrl_t                 ex_ctrl;
   logic                  ex_v;
   logic [REG_ADDR_W-1:0] ex_rd;

   mem_ctrl_t             mem_ctrl;
   logic                  mem_v;
   logic [REG_ADDR_W-1:0] mem_rd;

   wb_ctrl_t              wb_ctrl;
   logic                  wb_v;
   logic [REG_ADDR_W-1:0] wb_rd_q;

   logic                  rs_match;
   logic                  hazard;

   opcode_decoder u_opcode_decoder (
      .opcode  (id_opcode),
      .ctrl    (id_ctrl),
      .illegal (id_illegal)
   );

   assign id_take    = id_valid && !id_illegal;
   assign illegal_op = id_valid && id_illegal;

   // rs2 is compared even for formats without one; a spurious stall is harmless.
   assign rs_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
   assign hazard   = (HAZARD_EN != 0) && id_valid && ex_v && ex_ctrl.mem_read &&
                     (ex_rd != '0) && rs_match;
   assign load_use_stall = hazard;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_v     <= 1'b0;
         ex_ctrl  <= CTRL_NONE;
         ex_rd    <= '0;
         mem_v    <= 1'b0;
         mem_ctrl <= MEM_CTRL_NONE;
         mem_rd   <= '0;
         wb_v     <= 1'b0;
         wb_ctrl  <= WB_CTRL_NONE;
         wb_rd_q  <= '0;
      end else if (!stall_ext) begin
         // MEM/WB advances under flush too: the resolving branch in MEM must retire.
         wb_v    <= mem_v;
         wb_ctrl <= to_wb_ctrl(mem_ctrl);
         wb_rd_q <= mem_rd;

         if (flush) begin
            mem_v    <= 1'b0;
            mem_ctrl <= MEM_CTRL_NONE;
            mem_rd   <= '0;
         end else begin
            mem_v    <= ex_v;
            mem_ctrl <= to_mem_ctrl(ex_ctrl);
            mem_rd   <= ex_rd;
         end

         if (flush || hazard || !id_take) begin
            ex_v    <= 1'b0;
            ex_ctrl <= CTRL_NONE;
            ex_rd   <= '0;
         end else begin
            ex_v    <= 1'b1;
            ex_ctrl <= id_ctrl;
            ex_rd   <= id_rd;
         end
      end
   end

   assign ex_valid        = ex_v;
   assign ex_alu_op       = ALU_OP_W'(ex_ctrl.alu_op);
   assign ex_alu_src      = ex_ctrl.alu_src;
   assign ex_alu_src_a_pc = ex_ctrl.alu_src_a_pc;
   assign ex_branch       = ex_ctrl.branch;
   assign ex_jump         = ex_ctrl.jump;
   assign ex_jalr         = ex_ctrl.jalr;

   assign mem_valid     = mem_v;
   assign mem_mem_read  = mem_ctrl.mem_read;
   assign mem_mem_write = mem_ctrl.mem_write;
   assign mem_branch    = mem_ctrl.branch;
   assign mem_jump      = mem_ctrl.jump;

   assign wb_valid     = wb_v;
   assign wb_reg_write = wb_ctrl.reg_write;
   assign wb_mem_2_reg = wb_ctrl.mem_2_reg;
   assign wb_link      = wb_ctrl.link;
   assign wb_rd        = wb_rd_q;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Decodes the RISC-V opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers. It supersedes the single-cycle combinational control decoder for the 5-stage pipelined core.
- Adds LUI, AUIPC and JALR decoding, and link write-back for JAL/JALR.
- Adds load-use hazard detection, external stall and branch flush, with bubble insertion and per-stage valid bits.

Parameters:
REG_ADDR_W, 5, width of register specifiers rs1/rs2/rd
HAZARD_EN, 1, 1 = load-use detection active; 0 = load_use_stall tied low
ALU_OP_W, 2, ALUOp width (fixed encodings below; values >2 reserved)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk edge
id_valid  in  1  instruction in ID is valid
id_opcode  in  7  opcode[6:0] of instruction in ID
id_rs1  in  REG_ADDR_W  source 1 of ID instruction
id_rs2  in  REG_ADDR_W  source 2 of ID instruction
id_rd  in  REG_ADDR_W  destination of ID instruction
stall_ext  in  1  freeze entire pipeline (memory wait)
flush  in  1  branch/jump taken, resolved in MEM
load_use_stall  out  1  hold PC and IF/ID; combinational
illegal_op  out  1  id_valid and opcode not decoded; combinational
ex_valid, ex_alu_op[ALU_OP_W], ex_alu_src, ex_alu_src_a_pc, ex_branch, ex_jump, ex_jalr  out  ID/EX register
mem_valid, mem_mem_read, mem_mem_write, mem_branch, mem_jump  out  EX/MEM register
wb_valid, wb_reg_write, wb_mem_2_reg, wb_link, wb_rd[REG_ADDR_W]  out  MEM/WB register

Behaviour:
Decode is combinational, in ID. Opcodes:
- ALU_R 0110011: reg_write, alu_op=10.
- ALU_I 0010011: alu_src, reg_write, alu_op=00.
- LOAD 0000011: alu_src, mem_read, mem_2_reg, reg_write, alu_op=00.
- STORE 0100011: alu_src, mem_write, alu_op=00.
- BRANCH_EQ 1100011: branch, alu_op=01.
- JAL 1101111: branch, jump, reg_write, link, alu_op=00.
- JALR 1100111: jump, jalr, alu_src, reg_write, link, alu_op=00.
- LUI 0110111: alu_src, reg_write, alu_op=11 (pass B).
- AUIPC 0010111: alu_src, alu_src_a_pc, reg_write, alu_op=00.
- Any other opcode: all-zero bundle, illegal_op=id_valid.

Bubble: valid=0 and every control bit and rd = 0.

Reset (rst_n=0 at edge): all stage registers become bubbles. Every registered output reads 0 until the first valid instruction arrives; latency is ID to EX 1 cycle, to MEM 2 cycles, to WB 3 cycles.

load_use_stall = HAZARD_EN & id_valid & ex_valid & ex_mem_read_pending & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- The ID/EX register internally holds mem_read and rd for this comparison.
- rs2 is compared regardless of instruction format (conservative).

Per-edge priority (highest first):
1. !rst_n: all stages become bubbles.
2. stall_ext: all stages hold. flush and hazard are ignored; the flush source keeps flush high until stall_ext drops.
3. flush: ID/EX and EX/MEM take bubbles; MEM/WB takes the old EX/MEM contents (the branch itself retires).
4. load_use_stall: ID/EX takes a bubble; EX/MEM and MEM/WB advance.
5. Normal: ID/EX takes the decoded bundle gated by id_valid (invalid gives a bubble); EX/MEM and MEM/WB shift.

Boundary rules:
- An illegal opcode enters the pipeline as a bubble.
- flush and load_use in the same cycle: flush wins and no stall is reported past that edge.
- A reset asserted mid-stall clears everything in one cycle.
- rd=0 never raises a hazard.

Decomposition:
Package control_pkg holds:
- Opcode localparams: ALU_R, ALU_I, LOAD, STORE, BRANCH_EQ, JAL, JALR, LUI, AUIPC.
- ALUOp codes: ADD=00, SUB=01, R_TYPE=10, PASS_B=11.
- Control-bundle field widths.

Sub-module opcode_decoder is purely combinational: opcode in, bundle plus illegal flag out. The top level holds the three pipeline registers and the hazard and priority logic.

Test Plan:
- Reset then LOAD (rd=5) followed by ALU_R with rs1=5 → load_use_stall=1 for one cycle; ex_valid=0 the next cycle; ALU_R reaches EX one cycle later.
- LOAD rd=0 followed by consumer rs1=0 → load_use_stall stays 0.
- JAL in ID, then flush asserted two cycles later while two younger instructions are in flight → mem_valid=0 and ex_valid=0 after the edge; wb_link=1 and wb_reg_write=1 for the JAL.
- stall_ext held 3 cycles with a full pipeline → all outputs constant; resuming advances exactly one stage per cycle; flush held during the stall takes effect on the first unstalled edge.
- Sweep every opcode with id_valid=1 → EX bundle matches the decode rules 1 cycle later; opcode 0000000 gives illegal_op=1 and ex_valid=0.
- rst_n low for one cycle mid-stream with LUI in MEM → all outputs 0 on the next cycle; rst_n sampled only on clk edges (a glitch between edges has no effect).
